// File: rtl/xor_pkg.sv
// xor_pkg: shared state encoding and length-width helper for the XOR frame checksum
package xor_pkg;
  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_e;
  function automatic int len_width(input int max_len);
    return $clog2(max_len + 1);
  endfunction
endpackage

// File: rtl/nand_xor_vec.sv
// nand_xor_vec: bitwise a^b, each bit the classic four-NAND XOR cell
module nand_xor_vec #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);
  for (genvar g = 0; g < WIDTH; g++) begin : g_cell
    logic n1, n2, n3;
    assign n1 = ~(a[g] & b[g]);
    assign n2 = ~(a[g] & n1);
    assign n3 = ~(b[g] & n1);
    assign y[g] = ~(n2 & n3);
  end
endmodule

// File: rtl/xor_frame_checksum.sv
// xor_frame_checksum: folds a valid/ready word stream into a per-frame XOR checksum
module xor_frame_checksum
  import xor_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int MAX_LEN = 16,
  parameter int LEN_W   = len_width(MAX_LEN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  input  logic             chk_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_parity,
  output logic [LEN_W-1:0] out_len,
  output logic             out_err
);
  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d, nxt_acc;
  logic [LEN_W-1:0] len_q, len_d;
  logic             ovr_q, ovr_d, chk_q, chk_d;
  logic             beat, hold;

  nand_xor_vec #(.WIDTH(WIDTH)) u_xor (.a(acc_q), .b(in_data), .y(nxt_acc));

  assign hold     = state_q == HOLD;
  assign in_ready = !hold;
  assign beat     = in_valid & in_ready;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    len_d   = len_q;
    ovr_d   = ovr_q;
    chk_d   = chk_q;
    case (state_q)
      IDLE: if (beat) begin
        acc_d   = in_data;
        len_d   = LEN_W'(1);
        chk_d   = chk_en;
        state_d = in_last ? HOLD : ACCUM;
      end
      ACCUM: if (beat) begin
        acc_d   = nxt_acc;
        len_d   = (len_q < LEN_W'(MAX_LEN)) ? len_q + LEN_W'(1) : len_q;
        ovr_d   = ovr_q | (len_q >= LEN_W'(MAX_LEN));
        state_d = in_last ? HOLD : ACCUM;
      end
      HOLD: if (out_ready) begin
        state_d = IDLE;
        acc_d   = '0;
        len_d   = '0;
        ovr_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      len_q   <= '0;
      ovr_q   <= 1'b0;
      chk_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      len_q   <= len_d;
      ovr_q   <= ovr_d;
      chk_q   <= chk_d;
    end
  end

  assign out_valid  = hold;
  assign out_sum    = hold ? acc_q : '0;
  assign out_parity = hold & (^acc_q);
  assign out_len    = hold ? len_q : '0;
  assign out_err    = hold & ((chk_q & (acc_q != '0)) | ovr_q);
endmodule

// File: tb/tb_xor_frame_checksum.sv
// tb_xor_frame_checksum: scoreboard bench for xor_frame_checksum (WIDTH=8, MAX_LEN=4)
module tb_xor_frame_checksum;
  localparam int WIDTH = 8, MAX_LEN = 4, LEN_W = 3;

  logic clk = 0, rst = 1;
  logic in_valid = 0, in_ready, in_last = 0, chk_en = 0;
  logic [WIDTH-1:0] in_data = '0, out_sum;
  logic out_valid, out_ready = 1, out_parity, out_err;
  logic [LEN_W-1:0] out_len;

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic             par;
    logic [LEN_W-1:0] len;
    logic             err;
  } exp_t;

  exp_t             sb[$];
  logic [WIDTH-1:0] frm[$];
  int               n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  xor_frame_checksum #(.WIDTH(WIDTH), .MAX_LEN(MAX_LEN)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .chk_en(chk_en),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_parity(out_parity), .out_len(out_len), .out_err(out_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives frm as one frame; chk_en is inverted after the first beat to prove it is ignored.
  task automatic send_frame(input logic chk, input bit push);
    exp_t e;
    logic [WIDTH-1:0] acc = '0;
    int len = 0;
    bit ovr = 0;
    foreach (frm[i]) begin
      acc ^= frm[i];
      if (len < MAX_LEN) len++; else ovr = 1;
      check("in_ready_beat", in_ready, 1);
      in_valid = 1;
      in_data  = frm[i];
      in_last  = (i == frm.size() - 1);
      chk_en   = (i == 0) ? chk : ~chk;
      tick();
    end
    in_valid = 0;
    in_last  = 0;
    e.sum = acc;
    e.par = ^acc;
    e.len = LEN_W'(len);
    e.err = (chk && acc != 0) || ovr;
    if (push) sb.push_back(e);
  endtask

  task automatic collect();
    exp_t e;
    int k = 0;
    while (!out_valid && k < 20) begin
      tick();
      k++;
    end
    check("latency", k, 0);
    if (!out_valid || sb.size() == 0) begin
      check("result_present", 0, 1);
      return;
    end
    e = sb.pop_front();
    check("out_sum", out_sum, e.sum);
    check("out_parity", out_parity, e.par);
    check("out_len", out_len, e.len);
    check("out_err", out_err, e.err);
    check("in_ready_hold", in_ready, 0);
    out_ready = 1;
    tick();
    check("valid_drop", out_valid, 0);
    check("ready_back", in_ready, 1);
  endtask

  initial begin
    tick();
    tick();
    rst = 0;
    check("rst_valid", out_valid, 0);
    check("rst_ready", in_ready, 1);
    check("rst_sum", out_sum, 0);
    check("rst_len", out_len, 0);
    check("rst_err", out_err, 0);

    frm = '{8'h12, 8'h34, 8'h56};
    send_frame(0, 1);
    collect();

    frm = '{8'hA5, 8'h3C, 8'h99};
    send_frame(1, 1);
    collect();
    frm = '{8'hA5, 8'h3C, 8'h98};
    send_frame(1, 1);
    collect();

    out_ready = 0;
    frm = '{8'hFF};
    send_frame(0, 1);
    in_valid = 1;
    in_data  = 8'hAA;
    in_last  = 1;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", out_valid, 1);
      check("bp_sum", out_sum, 8'hFF);
      check("bp_len", out_len, 1);
      check("bp_ready", in_ready, 0);
      tick();
    end
    in_valid = 0;
    in_last  = 0;
    collect();

    frm = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20};
    send_frame(0, 1);
    collect();

    frm = '{8'h77, 8'h33};
    in_valid = 1;
    in_data  = 8'h77;
    tick();
    in_data = 8'h33;
    tick();
    in_valid = 0;
    rst = 1;
    tick();
    rst = 0;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_ready", in_ready, 1);
    tick();
    check("mid_rst_quiet", out_valid, 0);

    frm = '{8'h01};
    send_frame(0, 1);
    collect();

    check("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
